morse_stream_decoder: RTL and testbench

- Clocked, parametrised successor to the letter decoder.
- Accepts a serial stream of dot/dash symbols and assembles them into a 2-bit-per-symbol pattern: dot=01, dash=11, first symbol in the most significant occupied pair, right-aligned.
- On end-of-character, decodes the pattern to a character code (A-Z, optionally 0-9) and presents it on a valid/ready output.
- Sits between the key/timing front end and the display/buffer stage.

---
 rtl/morse_stream_decoder_if.sv | 33 +++
 rtl/morse_stream_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_morse_stream_decoder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_stream_decoder_if.sv
// ============================================================================
// Module   : morse_stream_decoder_if
// Brief    : Symbol-in / character-out handshake bundle for the Morse decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface morse_stream_decoder_if #(
    parameter int CNT_W = 16
);
    logic             sym_valid;
    logic             sym_dash;
    logic             letter_end;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_code;
    logic             out_error;
    logic [CNT_W-1:0] char_count;

    // master is the key front end plus display stage; slave is the decoder
    modport master (
        output sym_valid, sym_dash, letter_end, out_ready,
        input  in_ready, out_valid, out_code, out_error, char_count
    );

    modport slave (
        input  sym_valid, sym_dash, letter_end, out_ready,
        output in_ready, out_valid, out_code, out_error, char_count
    );
endinterface

`default_nettype wire

// File: rtl/morse_stream_decoder.sv
// ============================================================================
// Module   : morse_stream_decoder
// Brief    : Assembles dot/dash symbols into a pattern and emits A-Z / 0-9 codes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module morse_stream_decoder #(
    parameter int MAX_SYMBOLS   = 5,
    parameter int ENABLE_DIGITS = 1,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    morse_stream_decoder_if.slave  bus
);

    localparam int         PW     = 2 * MAX_SYMBOLS;
    localparam logic [3:0] SC_MAX = 4'(MAX_SYMBOLS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_LOOKUP  = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_pattern;
    logic [3:0]       r_sym_cnt;
    logic             r_ovf;
    logic             r_out_valid;
    logic [5:0]       r_out_code;
    logic             r_out_error;
    logic [CNT_W-1:0] r_char_count;

    logic             w_accepting;
    logic             w_sym_take;
    logic             w_room;
    logic             w_close;
    logic             w_handshake;
    logic [15:0]      w_pat16;
    logic [5:0]       w_raw_code;
    logic             w_is_digit;
    logic             w_digits_en;
    logic             w_dec_ok;
    logic [5:0]       w_dec_code;
    logic             w_dec_err;

    // Patterns are right-aligned and the leading pair is never 00, so
    // each symbol count maps onto a distinct zero-extended value.
    function automatic logic [5:0] f_lookup(input logic [15:0] p);
        case (p)
            16'b0111:       f_lookup = 6'd1;   // A
            16'b11010101:   f_lookup = 6'd2;   // B
            16'b11011101:   f_lookup = 6'd3;   // C
            16'b110101:     f_lookup = 6'd4;   // D
            16'b01:         f_lookup = 6'd5;   // E
            16'b01011101:   f_lookup = 6'd6;   // F
            16'b111101:     f_lookup = 6'd7;   // G
            16'b01010101:   f_lookup = 6'd8;   // H
            16'b0101:       f_lookup = 6'd9;   // I
            16'b01111111:   f_lookup = 6'd10;  // J
            16'b110111:     f_lookup = 6'd11;  // K
            16'b01110101:   f_lookup = 6'd12;  // L
            16'b1111:       f_lookup = 6'd13;  // M
            16'b1101:       f_lookup = 6'd14;  // N
            16'b111111:     f_lookup = 6'd15;  // O
            16'b01111101:   f_lookup = 6'd16;  // P
            16'b11110111:   f_lookup = 6'd17;  // Q
            16'b011101:     f_lookup = 6'd18;  // R
            16'b010101:     f_lookup = 6'd19;  // S
            16'b11:         f_lookup = 6'd20;  // T
            16'b010111:     f_lookup = 6'd21;  // U
            16'b01010111:   f_lookup = 6'd22;  // V
            16'b011111:     f_lookup = 6'd23;  // W
            16'b11010111:   f_lookup = 6'd24;  // X
            16'b11011111:   f_lookup = 6'd25;  // Y
            16'b11110101:   f_lookup = 6'd26;  // Z
            16'b1111111111: f_lookup = 6'd27;  // 0
            16'b0111111111: f_lookup = 6'd28;  // 1
            16'b0101111111: f_lookup = 6'd29;  // 2
            16'b0101011111: f_lookup = 6'd30;  // 3
            16'b0101010111: f_lookup = 6'd31;  // 4
            16'b0101010101: f_lookup = 6'd32;  // 5
            16'b1101010101: f_lookup = 6'd33;  // 6
            16'b1111010101: f_lookup = 6'd34;  // 7
            16'b1111110101: f_lookup = 6'd35;  // 8
            16'b1111111101: f_lookup = 6'd36;  // 9
            default:        f_lookup = 6'd0;
        endcase
    endfunction

    generate
        if (ENABLE_DIGITS != 0) begin : g_digits_on
            assign w_digits_en = 1'b1;
        end else begin : g_digits_off
            assign w_digits_en = 1'b0;
        end
    endgenerate

    always_comb begin
        w_accepting = (r_state == S_IDLE) || (r_state == S_COLLECT);
        w_sym_take  = w_accepting && bus.sym_valid;
        w_room      = (r_sym_cnt < SC_MAX);
        // A lone letter_end with nothing collected is not a character
        w_close     = w_accepting && bus.letter_end &&
                      (bus.sym_valid || (r_sym_cnt != 4'd0));
        w_handshake = (r_state == S_HOLD) && r_out_valid && bus.out_ready;
    end

    always_comb begin
        w_pat16             = '0;
        w_pat16[PW-1:0]     = r_pattern;
        w_raw_code          = f_lookup(w_pat16);
        w_is_digit          = (w_raw_code >= 6'd27);
        w_dec_ok            = (w_raw_code != 6'd0) && !r_ovf &&
                              (!w_is_digit || w_digits_en);
        w_dec_code          = w_dec_ok ? w_raw_code : 6'd0;
        w_dec_err           = !w_dec_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_close) begin
                    w_state_nxt = S_LOOKUP;
                end else if (bus.sym_valid) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_close) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern    <= '0;
            r_sym_cnt    <= 4'd0;
            r_ovf        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_code   <= 6'd0;
            r_out_error  <= 1'b0;
            r_char_count <= '0;
        end else begin
            if (w_sym_take) begin
                if (w_room) begin
                    r_pattern <= {r_pattern[PW-3:0], bus.sym_dash ? 2'b11 : 2'b01};
                    r_sym_cnt <= r_sym_cnt + 4'd1;
                end else begin
                    r_ovf     <= 1'b1;
                end
            end

            if (r_state == S_LOOKUP) begin
                r_out_code  <= w_dec_code;
                r_out_error <= w_dec_err;
                r_pattern   <= '0;
                r_sym_cnt   <= 4'd0;
                r_ovf       <= 1'b0;
            end

            // Valid rises one cycle into HOLD, after the code register settles
            if (r_state == S_HOLD) begin
                if (!r_out_valid) begin
                    r_out_valid  <= 1'b1;
                end else if (bus.out_ready) begin
                    r_out_valid  <= 1'b0;
                    r_char_count <= r_char_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready   = w_accepting;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_code   = r_out_code;
    assign bus.out_error  = r_out_error;
    assign bus.char_count = r_char_count;

endmodule

`default_nettype wire

// File: tb/tb_morse_stream_decoder.sv
// ============================================================================
// Module   : tb_morse_stream_decoder
// Brief    : Scoreboard bench driving two decoder variants with one symbol stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_morse_stream_decoder;

    localparam int MAXS = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sym_valid = 1'b0;
    logic sym_dash = 1'b0;
    logic letter_end = 1'b0;
    logic out_ready = 1'b1;
    int   rmode = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_hs = 0;
    string cur = "";

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    morse_stream_decoder_if #(.CNT_W(16)) bus_a();
    morse_stream_decoder_if #(.CNT_W(2))  bus_b();

    assign bus_a.sym_valid  = sym_valid;
    assign bus_a.sym_dash   = sym_dash;
    assign bus_a.letter_end = letter_end;
    assign bus_a.out_ready  = out_ready;
    assign bus_b.sym_valid  = sym_valid;
    assign bus_b.sym_dash   = sym_dash;
    assign bus_b.letter_end = letter_end;
    assign bus_b.out_ready  = out_ready;

    morse_stream_decoder #(.MAX_SYMBOLS(MAXS), .ENABLE_DIGITS(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset_n(rst_n), .bus(bus_a)
    );
    morse_stream_decoder #(.MAX_SYMBOLS(MAXS), .ENABLE_DIGITS(0), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset_n(rst_n), .bus(bus_b)
    );

    // Index i holds the Morse text for code i+1 (A..Z then 0..9)
    string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....",
                        "-....", "--...", "---..", "----."};

    typedef struct {
        logic [5:0] code_a;
        logic       err_a;
        logic [5:0] code_b;
        logic       err_b;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t cur_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input string s, input bit digits,
                                  output logic [5:0] code, output logic err);
        code = 6'd0;
        err  = 1'b1;
        if (s.len() > MAXS) return;
        for (int i = 0; i < 36; i++) begin
            if (s == tbl[i] && (i < 26 || digits)) begin
                code = 6'(i + 1);
                err  = 1'b0;
            end
        end
    endfunction

    task automatic close_char();
        exp_t e;
        model(cur, 1'b1, e.code_a, e.err_a);
        model(cur, 1'b0, e.code_b, e.err_b);
        e.due = cyc + 3;
        q.push_back(e);
        cur = "";
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus_a.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus_a.in_ready) chk("in_ready_timeout", 32'(bus_a.in_ready), 32'd1);
    endtask

    task automatic send_sym(input bit dash, input bit le);
        wait_ready();
        sym_valid  = 1'b1;
        sym_dash   = dash;
        letter_end = le;
        if (dash) cur = {cur, "-"};
        else      cur = {cur, "."};
        if (le) close_char();
        @(negedge clk);
        sym_valid  = 1'b0;
        letter_end = 1'b0;
    endtask

    task automatic send_end();
        wait_ready();
        letter_end = 1'b1;
        if (cur.len() > 0) close_char();
        @(negedge clk);
        letter_end = 1'b0;
    endtask

    task automatic send_str(input string s, input bit merge);
        for (int i = 0; i < s.len(); i++)
            send_sym(s[i] == "-", merge && (i == s.len() - 1));
        if (!merge) send_end();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || bus_a.out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 32'(q.size()), 32'd0);
        chk("drain_count_a", 32'(bus_a.char_count), 32'(exp_hs & 32'hFFFF));
        chk("drain_count_b", 32'(bus_b.char_count), 32'(exp_hs % 4));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus_a.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", 32'(bus_a.out_valid), 32'd1);
    endtask

    // Downstream ready: 0 = always, 1 = random, 2 = stalled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops an expectation on each new character and watches the hold
    initial begin
        bit active;
        bit prev_hs;
        active  = 1'b0;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active  = 1'b0;
                prev_hs = 1'b0;
                continue;
            end
            if (prev_hs) chk("valid_after_handshake", 32'(bus_a.out_valid), 32'd0);
            prev_hs = 1'b0;
            if (bus_a.out_valid) begin
                chk("valid_b", 32'(bus_b.out_valid), 32'd1);
                if (!active) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 32'(bus_a.out_valid), 32'd0);
                    end else begin
                        cur_e  = q.pop_front();
                        active = 1'b1;
                        chk("latency", 32'(cyc), 32'(cur_e.due));
                        chk("in_ready_hold", 32'(bus_a.in_ready), 32'd0);
                        chk("count_a", 32'(bus_a.char_count), 32'(exp_hs & 32'hFFFF));
                        chk("count_b", 32'(bus_b.char_count), 32'(exp_hs % 4));
                    end
                end
                if (active) begin
                    chk("code_a", 32'(bus_a.out_code), 32'(cur_e.code_a));
                    chk("err_a", 32'(bus_a.out_error), 32'(cur_e.err_a));
                    chk("code_b", 32'(bus_b.out_code), 32'(cur_e.code_b));
                    chk("err_b", 32'(bus_b.out_error), 32'(cur_e.err_b));
                    if (out_ready) begin
                        exp_hs++;
                        active  = 1'b0;
                        prev_hs = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("rst_code", 32'(bus_a.out_code), 32'd0);
        chk("rst_error", 32'(bus_a.out_error), 32'd0);
        chk("rst_count", 32'(bus_a.char_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send_str(".-", 1'b0);
        wait_drain();
        send_str("-----", 1'b0);
        wait_drain();
        send_str("......", 1'b0);
        send_str(".", 1'b0);
        wait_drain();

        // Stalled downstream; a symbol offered during HOLD must vanish
        rmode = 2;
        send_str("-", 1'b0);
        wait_valid();
        repeat (10) @(negedge clk);
        chk("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
        sym_valid  = 1'b1;
        sym_dash   = 1'b0;
        letter_end = 1'b1;
        @(negedge clk);
        sym_valid  = 1'b0;
        letter_end = 1'b0;
        rmode = 0;
        wait_drain();
        send_str("..", 1'b0);
        wait_drain();

        send_end();
        repeat (5) @(negedge clk);
        wait_drain();
        send_str(".", 1'b1);
        wait_drain();

        // Asynchronous reset mid-character
        send_sym(1'b0, 1'b0);
        send_sym(1'b1, 1'b0);
        send_sym(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("arst_code", 32'(bus_a.out_code), 32'd0);
        chk("arst_error", 32'(bus_a.out_error), 32'd0);
        chk("arst_count_a", 32'(bus_a.char_count), 32'd0);
        chk("arst_count_b", 32'(bus_b.char_count), 32'd0);
        cur    = "";
        exp_hs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_str("--", 1'b0);
        wait_drain();

        rmode = 1;
        for (int c = 0; c < 80; c++) begin
            int len;
            len = int'($urandom_range(1, 7));
            s = "";
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 1) == 1) s = {s, "-"};
                else                          s = {s, "."};
            end
            send_str(s, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rmode = 0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
